// File: rtl/axis_multi_adder_if.sv
// Stream bundle for axis_multi_adder: NUM_CH joined input channels and one widened output stream.
// The slave modport is the adder's view; the master modport drives the inputs and sinks the output.
interface axis_multi_adder_if #(
    parameter int NUM_CH        = 4,
    parameter int SAMPLES       = 16,
    parameter int SSAMPLE_WIDTH = 8,
    parameter int MSAMPLE_WIDTH = 16
);
    logic [NUM_CH*SAMPLES*SSAMPLE_WIDTH-1:0]   s_axis_tdata;
    logic [NUM_CH-1:0]                         s_axis_tvalid;
    logic [NUM_CH-1:0]                         s_axis_tlast;
    logic [NUM_CH-1:0]                         s_axis_tready;
    logic [SAMPLES*MSAMPLE_WIDTH-1:0]          m_axis_tdata;
    logic [SAMPLES*MSAMPLE_WIDTH/8-1:0]        m_axis_tkeep;
    logic                                      m_axis_tlast;
    logic                                      m_axis_tvalid;
    logic                                      m_axis_tready;

    modport slave (
        input  s_axis_tdata,
        input  s_axis_tvalid,
        input  s_axis_tlast,
        output s_axis_tready,
        output m_axis_tdata,
        output m_axis_tkeep,
        output m_axis_tlast,
        output m_axis_tvalid,
        input  m_axis_tready
    );

    modport master (
        output s_axis_tdata,
        output s_axis_tvalid,
        output s_axis_tlast,
        input  s_axis_tready,
        input  m_axis_tdata,
        input  m_axis_tkeep,
        input  m_axis_tlast,
        input  m_axis_tvalid,
        output m_axis_tready
    );
endinterface

// File: rtl/axis_multi_adder.sv
// Lane-wise join-and-add of NUM_CH AXI-Stream inputs into one widened stream, two register stages.
// Optional macro AXIS_ADDER_TLAST_CHECK_EN enables the sticky tlast mismatch flag (tied 0 otherwise).
module axis_multi_adder #(
    parameter int NUM_CH        = 4,
    parameter int SAMPLES       = 16,
    parameter int SSAMPLE_WIDTH = 8,
    parameter int MSAMPLE_WIDTH = 16
) (
    input  logic              CLK,
    input  logic              resetn,
    input  logic [NUM_CH-1:0] ch_enable,
    output logic              tlast_err,
    axis_multi_adder_if.slave bus
);
    localparam int SW     = SSAMPLE_WIDTH;
    localparam int MW     = MSAMPLE_WIDTH;
    localparam int OUT_W  = SAMPLES * MW;
    localparam int KEEP_W = OUT_W / 8;

    function automatic logic [MW-1:0] sext(input logic [SW-1:0] v);
        sext = {{(MW - SW){v[SW-1]}}, v};
    endfunction

    logic              w_joined;
    logic              w_s2_ready;
    logic              w_s1_ready;
    logic              w_fire;
    logic [NUM_CH-1:0] w_en_last;
    logic [OUT_W-1:0]  w_sum;

    logic              r_s1_valid;
    logic [OUT_W-1:0]  r_s1_data;
    logic              r_s1_last;
    logic              r_m_valid;
    logic [OUT_W-1:0]  r_m_data;
    logic              r_m_last;
    logic [KEEP_W-1:0] r_m_keep;

    // Join handshake; resetn gating keeps every ready low while reset is held.
    always_comb begin
        w_en_last  = bus.s_axis_tlast & ch_enable;
        w_joined   = &(bus.s_axis_tvalid | ~ch_enable);
        w_s2_ready = !r_m_valid | bus.m_axis_tready;
        w_s1_ready = !r_s1_valid | w_s2_ready;
        w_fire     = resetn & (|ch_enable) & w_joined & w_s1_ready;
    end

    assign bus.s_axis_tready = {NUM_CH{w_fire}} & ch_enable;

    // Per-lane sum of the sign-extended samples of the enabled channels.
    always_comb begin
        w_sum = {OUT_W{1'b0}};
        for (int j = 0; j < SAMPLES; j++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_enable[i]) begin
                    w_sum[j*MW +: MW] = w_sum[j*MW +: MW]
                                      + sext(bus.s_axis_tdata[(i*SAMPLES + j)*SW +: SW]);
                end else begin
                    w_sum[j*MW +: MW] = w_sum[j*MW +: MW];
                end
            end
        end
    end

    // Stage 1: captures the joined sum on fire, empties when stage 2 takes it.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= {OUT_W{1'b0}};
            r_s1_last  <= 1'b0;
        end else if (w_fire) begin
            r_s1_valid <= 1'b1;
            r_s1_data  <= w_sum;
            r_s1_last  <= |w_en_last;
        end else if (w_s2_ready) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Stage 2: output register, frozen while the downstream stalls a valid beat.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_m_valid <= 1'b0;
            r_m_data  <= {OUT_W{1'b0}};
            r_m_last  <= 1'b0;
            r_m_keep  <= {KEEP_W{1'b0}};
        end else if (w_s2_ready) begin
            r_m_valid <= r_s1_valid;
            r_m_keep  <= {KEEP_W{r_s1_valid}};
            if (r_s1_valid) begin
                r_m_data <= r_s1_data;
                r_m_last <= r_s1_last;
            end
        end
    end

    assign bus.m_axis_tdata  = r_m_data;
    assign bus.m_axis_tlast  = r_m_last;
    assign bus.m_axis_tvalid = r_m_valid;
    assign bus.m_axis_tkeep  = r_m_keep;

`ifdef AXIS_ADDER_TLAST_CHECK_EN
    logic w_last_mismatch;
    logic r_tlast_err;

    assign w_last_mismatch = (w_en_last != {NUM_CH{1'b0}}) && (w_en_last != ch_enable);

    // Sticky flag: enabled channels disagreed on tlast at some fire.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_tlast_err <= 1'b0;
        end else if (w_fire && w_last_mismatch) begin
            r_tlast_err <= 1'b1;
        end
    end

    assign tlast_err = r_tlast_err;
`else
    assign tlast_err = 1'b0;
`endif
endmodule

// File: tb/tb_axis_multi_adder.sv
// Directed and randomized self-checking bench for axis_multi_adder against a lane-sum reference model.
module tb_axis_multi_adder;
    localparam int NUM_CH  = 4;
    localparam int SAMPLES = 16;
    localparam int SW      = 8;
    localparam int MW      = 16;
    localparam int IN_W    = NUM_CH * SAMPLES * SW;
    localparam int BEAT_W  = SAMPLES * SW;
    localparam int OUT_W   = SAMPLES * MW;
    localparam int KEEP_W  = OUT_W / 8;
    localparam int NBEATS  = 1000;

    logic              CLK = 1'b0;
    logic              resetn;
    logic [NUM_CH-1:0] ch_enable;
    logic              tlast_err;
    int                checks = 0;
    int                errors = 0;

    axis_multi_adder_if #(.NUM_CH(NUM_CH), .SAMPLES(SAMPLES),
                          .SSAMPLE_WIDTH(SW), .MSAMPLE_WIDTH(MW)) bus ();

    axis_multi_adder #(.NUM_CH(NUM_CH), .SAMPLES(SAMPLES),
                       .SSAMPLE_WIDTH(SW), .MSAMPLE_WIDTH(MW)) dut (
        .CLK       (CLK),
        .resetn    (resetn),
        .ch_enable (ch_enable),
        .tlast_err (tlast_err),
        .bus       (bus)
    );

    always #5 CLK = ~CLK;

    logic [BEAT_W-1:0] beat_mem [NUM_CH][NBEATS];
    logic              last_mem [NBEATS];

    task automatic chk(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected output beat: signed per-lane sum over enabled channels, truncated to MW.
    function automatic logic [OUT_W-1:0] ref_sum(input logic [IN_W-1:0] d, input logic [NUM_CH-1:0] en);
        logic [OUT_W-1:0] r;
        r = '0;
        for (int j = 0; j < SAMPLES; j++) begin
            int s;
            s = 0;
            for (int i = 0; i < NUM_CH; i++) begin
                if (en[i]) begin
                    int v;
                    v = $signed(d[(i*SAMPLES + j)*SW +: SW]);
                    s = s + v;
                end
            end
            r[j*MW +: MW] = s[MW-1:0];
        end
        return r;
    endfunction

    function automatic logic [OUT_W-1:0] rep(input int v);
        logic [OUT_W-1:0] r;
        for (int j = 0; j < SAMPLES; j++) r[j*MW +: MW] = v[MW-1:0];
        return r;
    endfunction

    task automatic set_ch(input int ch, input int val);
        for (int j = 0; j < SAMPLES; j++) bus.s_axis_tdata[(ch*SAMPLES + j)*SW +: SW] = 8'(val);
    endtask

    // One directed beat through an empty pipeline; entered and left at posedge+1.
    task automatic send_beat(input string tag, input logic [NUM_CH-1:0] en, input logic [NUM_CH-1:0] last,
                             input logic [OUT_W-1:0] exp_data, input logic exp_last);
        ch_enable = en;
        bus.s_axis_tvalid = 4'b1111;
        bus.s_axis_tlast = last;
        bus.m_axis_tready = 1'b1;
        @(negedge CLK);
        chk({tag, " tready"}, OUT_W'(bus.s_axis_tready), OUT_W'(en));
        @(posedge CLK); #1;
        bus.s_axis_tvalid = 4'b0000;
        @(negedge CLK);
        chk({tag, " valid after 1 edge"}, OUT_W'(bus.m_axis_tvalid), OUT_W'(1'b0));
        @(negedge CLK);
        chk({tag, " valid after 2 edges"}, OUT_W'(bus.m_axis_tvalid), OUT_W'(1'b1));
        chk({tag, " data"}, bus.m_axis_tdata, exp_data);
        chk({tag, " last"}, OUT_W'(bus.m_axis_tlast), OUT_W'(exp_last));
        chk({tag, " keep"}, OUT_W'(bus.m_axis_tkeep), OUT_W'({KEEP_W{1'b1}}));
        @(posedge CLK); #1;
    endtask

    initial begin
        int               in_ptr [NUM_CH];
        logic             consumed [NUM_CH];
        int               out_cnt;
        int               cyc;
        logic             prev_stall;
        logic [OUT_W-1:0] prev_data;
        logic [IN_W-1:0]  exp_in;
        logic             exp_err;

`ifdef AXIS_ADDER_TLAST_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif

        // Reset state with inputs pushing
        resetn = 1'b0;
        ch_enable = 4'b1111;
        bus.s_axis_tdata = '0;
        bus.s_axis_tvalid = 4'b1111;
        bus.s_axis_tlast = 4'b0000;
        bus.m_axis_tready = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        chk("reset tready", OUT_W'(bus.s_axis_tready), OUT_W'(4'b0000));
        chk("reset tvalid", OUT_W'(bus.m_axis_tvalid), OUT_W'(1'b0));
        chk("reset tkeep", OUT_W'(bus.m_axis_tkeep), OUT_W'(1'b0));
        chk("reset tdata", bus.m_axis_tdata, OUT_W'(1'b0));
        chk("reset tlast_err", OUT_W'(tlast_err), OUT_W'(1'b0));
        bus.s_axis_tvalid = 4'b0000;
        @(posedge CLK); #1;
        resetn = 1'b1;

        // Max positive and max negative sums
        for (int i = 0; i < NUM_CH; i++) set_ch(i, 127);
        send_beat("sum 127x4", 4'b1111, 4'b0000, rep(508), 1'b0);
        for (int i = 0; i < NUM_CH; i++) set_ch(i, -128);
        send_beat("sum -128x4", 4'b1111, 4'b0000, rep(-512), 1'b0);

        // Masked channels 1 and 3
        set_ch(0, 10); set_ch(1, 20); set_ch(2, 30); set_ch(3, 40);
        send_beat("mask 0101", 4'b0101, 4'b0000, rep(40), 1'b0);

        // Channel 2 late: join must wait
        ch_enable = 4'b1111;
        bus.s_axis_tvalid = 4'b1011;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            chk("ch2 late tready", OUT_W'(bus.s_axis_tready), OUT_W'(4'b0000));
            @(posedge CLK); #1;
        end
        bus.s_axis_tvalid = 4'b1111;
        @(negedge CLK);
        chk("ch2 arrives tready", OUT_W'(bus.s_axis_tready), OUT_W'(4'b1111));
        @(posedge CLK); #1;
        bus.s_axis_tvalid = 4'b0000;
        repeat (3) @(posedge CLK);
        #1;

        // No channel enabled: nothing accepted
        ch_enable = 4'b0000;
        bus.s_axis_tvalid = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            chk("none enabled tready", OUT_W'(bus.s_axis_tready), OUT_W'(4'b0000));
            chk("none enabled tvalid", OUT_W'(bus.m_axis_tvalid), OUT_W'(1'b0));
            @(posedge CLK); #1;
        end
        bus.s_axis_tvalid = 4'b0000;

        // Disagreeing tlast bits; output last is their OR
        for (int i = 0; i < NUM_CH; i++) set_ch(i, i + 1);
        send_beat("tlast 0011", 4'b1111, 4'b0011, rep(10), 1'b1);
        chk("tlast_err set", OUT_W'(tlast_err), OUT_W'(exp_err));
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("tlast_err sticky", OUT_W'(tlast_err), OUT_W'(exp_err));
        @(posedge CLK); #1;

        // Fill both stages with downstream stalled
        bus.m_axis_tready = 1'b0;
        bus.s_axis_tlast = 4'b0000;
        bus.s_axis_tvalid = 4'b1111;
        for (int i = 0; i < NUM_CH; i++) set_ch(i, 1);
        @(negedge CLK);
        chk("fill A tready", OUT_W'(bus.s_axis_tready), OUT_W'(4'b1111));
        @(posedge CLK); #1;
        for (int i = 0; i < NUM_CH; i++) set_ch(i, 2);
        @(negedge CLK);
        chk("fill B tready", OUT_W'(bus.s_axis_tready), OUT_W'(4'b1111));
        @(posedge CLK); #1;
        for (int i = 0; i < NUM_CH; i++) set_ch(i, 3);
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            chk("full tready", OUT_W'(bus.s_axis_tready), OUT_W'(4'b0000));
            chk("full held data", bus.m_axis_tdata, rep(4));
            chk("full held valid", OUT_W'(bus.m_axis_tvalid), OUT_W'(1'b1));
            @(posedge CLK); #1;
        end

        // Asynchronous reset in the middle of the stall
        @(negedge CLK); #1;
        resetn = 1'b0;
        #1;
        chk("async rst tvalid", OUT_W'(bus.m_axis_tvalid), OUT_W'(1'b0));
        chk("async rst tkeep", OUT_W'(bus.m_axis_tkeep), OUT_W'(1'b0));
        chk("async rst tready", OUT_W'(bus.s_axis_tready), OUT_W'(4'b0000));
        chk("async rst tlast_err", OUT_W'(tlast_err), OUT_W'(1'b0));
        bus.s_axis_tvalid = 4'b0000;
        bus.m_axis_tready = 1'b1;
        @(posedge CLK); #1;
        resetn = 1'b1;
        @(negedge CLK);
        chk("post rst tvalid", OUT_W'(bus.m_axis_tvalid), OUT_W'(1'b0));
        @(posedge CLK); #1;

        // Random traffic with downstream back-pressure against the lane-sum model
        for (int k = 0; k < NBEATS; k++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                for (int j = 0; j < BEAT_W / 32; j++) beat_mem[i][k][j*32 +: 32] = $urandom;
            end
            last_mem[k] = ($urandom_range(0, 7) == 0);
        end
        for (int i = 0; i < NUM_CH; i++) begin
            in_ptr[i] = 0;
            consumed[i] = 1'b0;
        end
        ch_enable = 4'b1111;
        bus.s_axis_tvalid = 4'b0000;
        out_cnt = 0;
        cyc = 0;
        prev_stall = 1'b0;
        prev_data = '0;
        while (out_cnt < NBEATS && cyc < 20000) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (consumed[i]) begin
                    in_ptr[i]++;
                    bus.s_axis_tvalid[i] = 1'b0;
                    consumed[i] = 1'b0;
                end
                if (in_ptr[i] < NBEATS) begin
                    if (!bus.s_axis_tvalid[i]) bus.s_axis_tvalid[i] = ($urandom_range(0, 3) != 0);
                    bus.s_axis_tdata[i*BEAT_W +: BEAT_W] = beat_mem[i][in_ptr[i]];
                    bus.s_axis_tlast[i] = last_mem[in_ptr[i]];
                end else begin
                    bus.s_axis_tvalid[i] = 1'b0;
                end
            end
            bus.m_axis_tready = $urandom_range(0, 1) == 1;
            @(negedge CLK);
            if (prev_stall) begin
                chk("stall valid held", OUT_W'(bus.m_axis_tvalid), OUT_W'(1'b1));
                chk("stall data held", bus.m_axis_tdata, prev_data);
            end
            if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                for (int i = 0; i < NUM_CH; i++) exp_in[i*BEAT_W +: BEAT_W] = beat_mem[i][out_cnt];
                chk("random data", bus.m_axis_tdata, ref_sum(exp_in, 4'b1111));
                chk("random last", OUT_W'(bus.m_axis_tlast), OUT_W'(last_mem[out_cnt]));
                out_cnt++;
            end
            for (int i = 0; i < NUM_CH; i++) consumed[i] = bus.s_axis_tvalid[i] & bus.s_axis_tready[i];
            prev_stall = bus.m_axis_tvalid & ~bus.m_axis_tready;
            prev_data = bus.m_axis_tdata;
            @(posedge CLK); #1;
            cyc++;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (consumed[i]) in_ptr[i]++;
        end
        chk("random output count", OUT_W'(out_cnt), OUT_W'(NBEATS));
        for (int i = 0; i < NUM_CH; i++) chk("random input count", OUT_W'(in_ptr[i]), OUT_W'(NBEATS));
        bus.s_axis_tvalid = 4'b0000;
        bus.m_axis_tready = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("drained tvalid", OUT_W'(bus.m_axis_tvalid), OUT_W'(1'b0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
